// File: rtl/within_gen_pkg.sv
// Shared types and arithmetic for the within-operator stimulus generator.
// Config fields are carried at CW bits; the top zero-extends its W-bit inputs.
package within_gen_pkg;

    localparam int CW = 16;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        FRAME
    } state_t;

    typedef struct packed {
        logic [CW-1:0] b_len;
        logic [CW-1:0] a_len;
        logic [CW-1:0] a_off;
    } cfg_t;

    // Frame covers both the b/c span and the whole a window.
    function automatic logic [CW:0] calc_frame_len(cfg_t c);
        logic [CW:0] bc;
        logic [CW:0] ac;
        bc = {1'b0, c.b_len} + (CW+1)'(1);
        ac = {1'b0, c.a_off} + {1'b0, c.a_len};
        return (bc > ac) ? bc : ac;
    endfunction

    function automatic logic calc_expect_pass(cfg_t c);
        logic [CW:0] a_end;
        logic [CW:0] bc;
        a_end = {1'b0, c.a_off} + {1'b0, c.a_len};
        bc    = {1'b0, c.b_len} + (CW+1)'(1);
        return a_end <= bc;
    endfunction

endpackage

// File: rtl/within_seq_gen_window_pulse.sv
// Window decoder: hit while start <= k < start + len.
// The end bound is formed one bit wider so it cannot overflow.
module window_pulse #(
    parameter int N = 5
) (
    input  logic [N-1:0] k,
    input  logic [N-1:0] start,
    input  logic [N-1:0] len,
    output logic         hit
);

    logic [N:0] stop;

    assign stop = {1'b0, start} + {1'b0, len};
    assign hit  = (k >= start) && ({1'b0, k} < stop);

endmodule

// File: rtl/within_seq_gen.sv
// Generates a/b/c frames for `a[*n] within (b[*m] ##1 c)` checks,
// with a registered pass/fail prediction per frame.
module within_seq_gen #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] cfg_b_len,
    input  logic [W-1:0] cfg_a_len,
    input  logic [W-1:0] cfg_a_off,
    output logic         busy,
    output logic         done,
    output logic         b_out,
    output logic         c_out,
    output logic         a_out,
    output logic         expect_pass
);

    import within_gen_pkg::*;

    localparam int N = W + 1;

    state_t      state;
    state_t      state_d;
    logic [N-1:0] k;
    logic [N-1:0] k_d;
    cfg_t        cfg_q;
    cfg_t        cfg_d;
    logic [CW:0] flen;
    logic        last;
    logic        accept;
    logic        hit_b;
    logic        hit_a;
    logic        hit_c;

    function automatic logic [CW-1:0] clamp(logic [W-1:0] v);
        return (v == '0) ? CW'(1) : CW'(v);
    endfunction

    always_comb begin
        cfg_d.b_len = clamp(cfg_b_len);
        cfg_d.a_len = clamp(cfg_a_len);
        cfg_d.a_off = CW'(cfg_a_off);
    end

    assign flen   = calc_frame_len(cfg_q);
    assign last   = ((CW+1)'(k) == flen - (CW+1)'(1));
    assign accept = start && !busy && (state == IDLE);
    assign hit_c  = (k == N'(cfg_q.b_len));

    window_pulse #(.N(N)) u_win_b (
        .k     (k),
        .start ('0),
        .len   (N'(cfg_q.b_len)),
        .hit   (hit_b)
    );

    window_pulse #(.N(N)) u_win_a (
        .k     (k),
        .start (N'(cfg_q.a_off)),
        .len   (N'(cfg_q.a_len)),
        .hit   (hit_a)
    );

    always_comb begin
        state_d = state;
        k_d     = k;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_d = LEAD;
                    k_d     = '0;
                end
            end
            LEAD: state_d = FRAME;
            FRAME: begin
                k_d = k + N'(1);
                if (last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // busy stays up one cycle past FRAME so the clearing edge owns done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            k           <= '0;
            cfg_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            b_out       <= 1'b0;
            c_out       <= 1'b0;
            a_out       <= 1'b0;
            expect_pass <= 1'b0;
        end else begin
            state <= state_d;
            k     <= k_d;
            done  <= 1'b0;
            if (accept) begin
                cfg_q       <= cfg_d;
                expect_pass <= calc_expect_pass(cfg_d);
                busy        <= 1'b1;
            end else if (state == IDLE && busy) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            b_out <= (state == FRAME) && hit_b;
            c_out <= (state == FRAME) && hit_c;
            a_out <= (state == FRAME) && hit_a;
        end
    end

endmodule
